// File: rtl/nor_bank_pkg.sv
// Shared types and constants for the nor_bank NOR-gate bank.
// Fault logic is present only when NOR_BANK_FAULT_EN is defined.
package nor_bank_pkg;

    // Per-channel fault mode; encoding matches the fi_mode input field.
    typedef enum logic [1:0] {
        FI_CLEAR  = 2'b00,
        FI_STUCK0 = 2'b01,
        FI_STUCK1 = 2'b10,
        FI_INVERT = 2'b11
    } fi_mode_e;

    // Fault request handshake states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_APPLY = 1'b1
    } fi_state_e;

    localparam int unsigned CNT_W_DEFAULT = 16;

    // Apply a channel's fault mode to its raw delayed NOR value.
    function automatic logic fault_mask(input fi_mode_e mode, input logic y_raw);
        logic r;
        case (mode)
            FI_STUCK0: r = 1'b0;
            FI_STUCK1: r = 1'b1;
            FI_INVERT: r = ~y_raw;
            default:   r = y_raw;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/nor_bank_delay.sv
// One-bit registered delay line, DELAY_CYC stages deep, async reset to IV.
module nor_delay_line #(
    parameter int unsigned DELAY_CYC = 1,
    parameter logic        IV        = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [DELAY_CYC-1:0] stage_q;

    // A single-stage line has no slice to shift, so it gets its own branch.
    if (DELAY_CYC == 1) begin : g_one
        // Capture the input every cycle.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                stage_q <= IV;
            end else begin
                stage_q <= d_i;
            end
        end
    end else begin : g_multi
        // Shift toward the MSB; the MSB is the oldest sample.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                stage_q <= {DELAY_CYC{IV}};
            end else begin
                stage_q <= {stage_q[DELAY_CYC-2:0], d_i};
            end
        end
    end

    assign q_o = stage_q[DELAY_CYC-1];

endmodule

// File: rtl/nor_bank.sv
// Bank of WIDTH NIN-input NOR gates with per-channel registered delay,
// optional fault injection (NOR_BANK_FAULT_EN) and a saturating
// output-transition counter.
module nor_bank
    import nor_bank_pkg::*;
#(
    parameter int unsigned       WIDTH     = 8,
    parameter int unsigned       NIN       = 3,
    parameter int unsigned       DELAY_CYC = 1,
    parameter logic [WIDTH-1:0]  IV        = '0,
    parameter int unsigned       CNT_W     = CNT_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH*NIN-1:0]  a,
    output logic [WIDTH-1:0]      y,
    input  logic                  fi_valid,
    output logic                  fi_ready,
    input  logic [5:0]            fi_chan,
    input  logic [1:0]            fi_mode,
    output logic                  fi_err,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      tcount
);

    logic [WIDTH-1:0] nor_c;
    logic [WIDTH-1:0] y_raw;

    // Per-channel NOR reduction of the input slice.
    always_comb begin
        nor_c = '0;
        for (int unsigned c = 0; c < WIDTH; c++) begin
            nor_c[c] = ~|a[c*NIN +: NIN];
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_dl
        nor_delay_line #(
            .DELAY_CYC (DELAY_CYC),
            .IV        (IV[g])
        ) u_dl (
            .clk_i (clk),
            .rst_i (rst),
            .d_i   (nor_c[g]),
            .q_o   (y_raw[g])
        );
    end

`ifdef NOR_BANK_FAULT_EN
    fi_state_e  state_q, state_d;
    logic [5:0] chan_q;
    fi_mode_e   mode_q;
    fi_mode_e   fault_q [WIDTH];
    logic       err_q;
    logic       chan_bad;

    assign chan_bad = (32'(chan_q) >= WIDTH);

    // Next handshake state: accept in IDLE, always return from APPLY.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (fi_valid) state_d = ST_APPLY;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Handshake state and request latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            chan_q  <= '0;
            mode_q  <= FI_CLEAR;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && fi_valid) begin
                chan_q <= fi_chan;
                mode_q <= fi_mode_e'(fi_mode);
            end
        end
    end

    // Fault register write in APPLY; out-of-range channel only raises fi_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned c = 0; c < WIDTH; c++) begin
                fault_q[c] <= FI_CLEAR;
            end
            err_q <= 1'b0;
        end else begin
            err_q <= (state_q == ST_APPLY) && chan_bad;
            if (state_q == ST_APPLY) begin
                for (int unsigned c = 0; c < WIDTH; c++) begin
                    if (chan_q == 6'(c)) begin
                        fault_q[c] <= mode_q;
                    end
                end
            end
        end
    end

    // Output masking straight from the fault registers.
    always_comb begin
        y = '0;
        for (int unsigned c = 0; c < WIDTH; c++) begin
            y[c] = fault_mask(fault_q[c], y_raw[c]);
        end
    end

    assign fi_ready = (state_q == ST_IDLE);
    assign fi_err   = err_q;
`else
    logic unused_fi;

    assign unused_fi = ^{fi_valid, fi_chan, fi_mode};
    assign y         = y_raw;
    assign fi_ready  = 1'b0;
    assign fi_err    = 1'b0;
`endif

    logic [WIDTH-1:0] y_prev_q;
    logic [CNT_W-1:0] tcount_q, tcount_d;

    // Saturating transition count; clear wins over an increment.
    always_comb begin
        tcount_d = tcount_q;
        if (cnt_clr) begin
            tcount_d = '0;
        end else if ((y != y_prev_q) && (tcount_q != '1)) begin
            tcount_d = tcount_q + CNT_W'(1);
        end
    end

    // Previous-output register and counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_prev_q <= IV;
            tcount_q <= '0;
        end else begin
            y_prev_q <= y;
            tcount_q <= tcount_d;
        end
    end

    assign tcount = tcount_q;

endmodule

// File: tb/tb_nor_bank.sv
// Directed self-checking bench for nor_bank (WIDTH=8, NIN=3, DELAY_CYC=3,
// IV=8'hA5, CNT_W=4). Fault steps run when NOR_BANK_FAULT_EN is defined.
module tb_nor_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] a;
    logic [7:0]  y;
    logic        fi_valid;
    logic        fi_ready;
    logic [5:0]  fi_chan;
    logic [1:0]  fi_mode;
    logic        fi_err;
    logic        cnt_clr;
    logic [3:0]  tcount;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef NOR_BANK_FAULT_EN
    localparam logic FR_IDLE = 1'b1;
`else
    localparam logic FR_IDLE = 1'b0;
`endif

    always #5 clk = ~clk;

    nor_bank #(
        .WIDTH     (8),
        .NIN       (3),
        .DELAY_CYC (3),
        .IV        (8'hA5),
        .CNT_W     (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .y        (y),
        .fi_valid (fi_valid),
        .fi_ready (fi_ready),
        .fi_chan  (fi_chan),
        .fi_mode  (fi_mode),
        .fi_err   (fi_err),
        .cnt_clr  (cnt_clr),
        .tcount   (tcount)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; a = 24'hFFFFF8; fi_valid = 1'b0; fi_chan = '0; fi_mode = '0; cnt_clr = 1'b0;
        tick(); tick();
        chk("rst_y", y, 8'hA5);
        chk("rst_tcount", tcount, 4'd0);
        chk("rst_ready", fi_ready, FR_IDLE);
        chk("rst_err", fi_err, 1'b0);

        rst = 1'b0;
        tick(); chk("first_cap_y", y, 8'hA5);
        tick(); tick();
        chk("settle_y", y, 8'h01);
        chk("settle_cnt_pre", tcount, 4'd0);
        tick(); chk("settle_cnt", tcount, 4'd1);
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        chk("clr", tcount, 4'd0);

        // channel 0 inputs 000 -> 001: y[0] falls after the third edge
        a = 24'hFFFFF9;
        tick(); chk("lat_e1", y, 8'h01);
        tick(); chk("lat_e2", y, 8'h01);
        tick(); chk("lat_e3", y, 8'h00);
        chk("lat_cnt_e3", tcount, 4'd0);
        tick(); chk("lat_cnt_e4", tcount, 4'd1);

        // toggle channel 0 every cycle; counter saturates at 15
        for (int i = 0; i < 20; i++) begin
            a = (i % 2 == 0) ? 24'hFFFFF8 : 24'hFFFFF9;
            tick();
            if (i == 9) chk("sat_mid", tcount, 4'd8);
        end
        chk("sat", tcount, 4'd15);
        a = 24'hFFFFF8; cnt_clr = 1'b1; tick();
        chk("sat_clr_vs_inc", tcount, 4'd0);
        cnt_clr = 1'b0; a = 24'hFFFFF9; tick();
        chk("post_clr", tcount, 4'd1);

`ifdef NOR_BANK_FAULT_EN
        a = 24'hFFFFF9; cnt_clr = 1'b1;
        repeat (4) tick();
        cnt_clr = 1'b0;
        chk("f_base_y", y, 8'h00);

        fi_valid = 1'b1; fi_chan = 6'd2; fi_mode = 2'b10;
        chk("f_rdy_pre", fi_ready, 1'b1);
        tick();
        chk("f_rdy_low", fi_ready, 1'b0);
        chk("f_y_k", y, 8'h00);
        fi_valid = 1'b0;
        tick();
        chk("f_rdy_back", fi_ready, 1'b1);
        chk("f_y_stuck1", y, 8'h04);
        chk("f_err_none", fi_err, 1'b0);
        chk("f_cnt_k1", tcount, 4'd0);
        tick(); chk("f_cnt_k2", tcount, 4'd1);

        a = 24'hFFFE39;
        repeat (3) tick();
        chk("f_stuck_hold", y, 8'h04);
        chk("f_cnt_masked", tcount, 4'd1);

        fi_valid = 1'b1; fi_mode = 2'b11; tick(); fi_valid = 1'b0; tick();
        chk("f_inv", y, 8'h00);
        fi_valid = 1'b1; fi_mode = 2'b00; tick(); fi_valid = 1'b0; tick();
        chk("f_clear", y, 8'h04);

        fi_valid = 1'b1; fi_chan = 6'd9; fi_mode = 2'b10; tick();
        chk("f_bad_err_k", fi_err, 1'b0);
        fi_valid = 1'b0; tick();
        chk("f_bad_err", fi_err, 1'b1);
        chk("f_bad_y", y, 8'h04);
        tick();
        chk("f_bad_err_end", fi_err, 1'b0);
        chk("f_bad_y2", y, 8'h04);

        // valid held through APPLY is ignored; back to IDLE afterwards
        fi_valid = 1'b1; fi_chan = 6'd2; fi_mode = 2'b01; tick(); tick();
        chk("f_held_rdy", fi_ready, 1'b1);
        fi_valid = 1'b0;
        chk("f_stuck0", y, 8'h00);
`else
        fi_valid = 1'b1; fi_chan = 6'd2; fi_mode = 2'b10;
        a = 24'hFFFE39; cnt_clr = 1'b1;
        tick();
        chk("nf_rdy", fi_ready, 1'b0);
        chk("nf_err", fi_err, 1'b0);
        tick(); tick(); tick();
        cnt_clr = 1'b0;
        chk("nf_y", y, 8'h04);
        chk("nf_rdy2", fi_ready, 1'b0);
        a = 24'hFFFFF9;
        tick(); tick(); tick();
        chk("nf_y2", y, 8'h00);
        chk("nf_err2", fi_err, 1'b0);
        tick(); chk("nf_cnt", tcount, 4'd1);
`endif

        // asynchronous reset mid-stream, away from any clock edge
        a = 24'hFFFE39;
        #3; rst = 1'b1; #1;
        chk("ar_y", y, 8'hA5);
        chk("ar_cnt", tcount, 4'd0);
        chk("ar_rdy", fi_ready, FR_IDLE);
        chk("ar_err", fi_err, 1'b0);
        tick(); chk("ar_hold", y, 8'hA5);
        rst = 1'b0;
        tick(); chk("ar_e1", y, 8'hA5);
        tick(); chk("ar_e2", y, 8'hA5);
        tick(); chk("ar_e3", y, 8'h04);
        tick(); chk("ar_cnt1", tcount, 4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nor_bank.md
# nor_bank

Parametrised bank of WIDTH independent NIN-input NOR gates for the cycle-based (FPGA) simulation target. Each gate's result passes through a registered delay line of DELAY_CYC clock cycles. The delay line stands in for the analogue `#delay` used by the event-driven models. The block adds per-channel fault injection, loaded over a valid/ready handshake, and a saturating output-transition counter for activity checks. It replaces groups of single NOR gate instances wherever a whole logic row is modelled at once.

## Interface
- WIDTH, 8, number of NOR channels (1..64)
- NIN, 3, inputs per NOR gate (1..8)
- DELAY_CYC, 1, output latency in clock cycles (1..16)
- IV, {WIDTH{1'b0}}, reset/initial value of every delay stage and of y
- CNT_W, 16, transition counter width

- clk  in  1  simulation clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- a  in  WIDTH*NIN  gate inputs; channel c uses bits [c*NIN +: NIN]
- y  out  WIDTH  delayed NOR outputs, after fault masking
- fi_valid  in  1  fault request valid
- fi_ready  out  1  fault request accepted when fi_valid & fi_ready at posedge
- fi_chan  in  6  target channel index
- fi_mode  in  2  00 clear, 01 stuck-0, 10 stuck-1, 11 invert
- fi_err  out  1  one-cycle pulse: accepted request had fi_chan >= WIDTH
- cnt_clr  in  1  synchronous clear of tcount
- tcount  out  CNT_W  number of cycles in which y changed, saturating

## Operation
- Per channel c: nor_c = ~|a[c*NIN +: NIN].
- Stage 0 captures nor_c at each posedge. Stage i captures stage i-1. y_raw = stage DELAY_CYC-1.
- Fault masking applies to y_raw per channel, combinationally from registers:
  - clear: y_raw
  - stuck-0: 0
  - stuck-1: 1
  - invert: ~y_raw
- Fault handshake FSM:
  - IDLE: fi_ready=1. On fi_valid, latch fi_chan/fi_mode and go to APPLY.
  - APPLY: fi_ready=0. Write the mode to the target channel's fault register, or pulse fi_err if fi_chan >= WIDTH and change nothing. Return to IDLE.
- Only one request is accepted per two cycles. fi_valid asserted during APPLY is ignored; the requester holds it until fi_ready.
- Transition counter:
  - y_prev registers y.
  - Each cycle with y != y_prev (any bit), tcount increments, saturating at 2^CW-1 with no wrap.
  - cnt_clr has priority over an increment in the same cycle: result 0.
- Reset, asserted at any time: all delay stages = IV, y = IV with all faults cleared, y_prev = IV, tcount = 0, FSM = IDLE (fi_ready = 1), fi_err = 0. Any in-flight request is discarded.

## Timing
- a stable before posedge k → y reflects it after posedge k+DELAY_CYC-1, i.e. DELAY_CYC cycles of latency.
- A fault accepted at posedge k is written at posedge k+1. y reflects it immediately after k+1. fi_err is high during cycle k+1..k+2.
- fi_ready falls after posedge k and rises after k+1.
- A y change caused by a fault write counts as a transition at the following posedge.
- Release of rst is asynchronous; the first capture happens at the first posedge with rst low.

## Configuration
- NOR_BANK_FAULT_EN defined: fault registers, FSM and masking are present as described.
- Not defined:
  - y = y_raw
  - fi_ready tied 0, fi_err tied 0
  - fi_* inputs unused; no fault state exists
- The counter and delay line are identical in both builds.

## Structure
- nor_bank_pkg holds:
  - fault-mode enum (FI_CLEAR, FI_STUCK0, FI_STUCK1, FI_INVERT)
  - FSM state enum (ST_IDLE, ST_APPLY)
  - default CNT_W constant
- Sub-module nor_delay_line: one-bit, DELAY_CYC-deep shift register with async reset to a per-instance IV bit. It is instantiated WIDTH times via generate.
- The top level holds the NOR reduction, fault logic, FSM and counter.

## Test plan
- Reset: WIDTH=8, IV=8'hA5, hold rst → y=8'hA5, tcount=0, fi_ready=1. Assert rst mid-stream → same values asynchronously.
- Latency: DELAY_CYC=3, channel 0 inputs go from 000 to 001 before edge 10 → y[0] falls after edge 12, not earlier. tcount increments by 1 at edge 13.
- Fault: request chan 2 stuck-1 accepted at edge k → fi_ready low one cycle, y[2]=1 after k+1 regardless of inputs. Mode invert then clear restores nor value.
- Bad channel: fi_chan=9 with WIDTH=8 → fi_err pulses one cycle, y unchanged, fault state unchanged.
- Counter: CNT_W=4, toggle input every cycle for 20 cycles → tcount saturates at 15. cnt_clr coinciding with a toggle → 0.
- Build without NOR_BANK_FAULT_EN: drive fi_valid=1 continuously → fi_ready=0, y tracks pure delayed NOR.
